lbm_config_loader: RTL and testbench
====================================

# lbm_config_loader

Upstream configuration stage for the LBM solver top. It accepts one configuration packet over a 64-bit AXI-Stream slave: header, nine initial distribution values, run length and the barrier mask. It holds the packet in shadow registers and commits it atomically to the solver's `barriers`, `omega`, `step` and `init_*` inputs. It then drives `en` for a configured number of output frames, counted from the solver DMA's `m00_axis` tlast handshakes.

## Interface
Parameters:
- `DEPTH`, 2500 — lattice cells; width of `barriers`.
- `DATA_WIDTH`, 16 — width of each `init_*` value.
- `BAR_BEATS`, ceil(DEPTH/64) = 40 — barrier beats per packet.

Ports:
- `clk` in 1 — single clock; all logic on rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `s00_axis_tvalid` in 1 — config beat valid.
- `s00_axis_tdata` in 64 — config beat data.
- `s00_axis_tstrb` in 8 — ignored; all beats treated as full.
- `s00_axis_tlast` in 1 — final beat of packet.
- `s00_axis_tready` out 1 — loader accepts beat.
- `frame_done` in 1 — one-cycle pulse on each `m00_axis_tvalid & tready & tlast` of the solver DMA.
- `abort` in 1 — one-cycle pulse; stop current run.
- `barriers` out DEPTH — committed barrier mask; bit i = cell i.
- `omega` out 16 signed — committed relaxation factor.
- `step` out 32 — committed step value.
- `init_c0`, `init_cn`, `init_cne`, `init_ce`, `init_cse`, `init_cs`, `init_csw`, `init_cw`, `init_cnw` out DATA_WIDTH each — committed initial distributions.
- `en` out 1 — solver enable.
- `busy` out 1 — high while in RUN.
- `done` out 1 — one-cycle pulse on normal run completion.
- `err` out 1 — sticky packet-format error.

## Operation
Packet layout. Fields are listed LSB first; 44 beats when DEPTH = 2500.
- Beat 0: [15:0] magic 16'h4C42; [31:16] omega; [63:32] step.
- Beat 1: c0, cn, cne, ce.
- Beat 2: cse, cs, csw, cw.
- Beat 3: [15:0] cnw; [31:16] frames; [63:32] reserved.
- Beats 4..4+BAR_BEATS-1: barrier bits, beat k bit j → cell 64k+j. Bits ≥ DEPTH in the last beat are ignored.
- tlast is required on the last barrier beat only.

FSM states: HDR, CFG, BAR, DRAIN, RUN. A beat counter (6 bits) tracks the beat index.
- HDR → CFG on a header handshake with good magic. A bad magic goes to DRAIN and sets `err`; if that beat has tlast, go to HDR instead.
- CFG covers beats 1–3, then → BAR. tlast on any beat before the final beat → HDR, sets `err`, no commit.
- BAR on the final beat:
  - With tlast → commit all shadow registers to the outputs, clear `err`, clear the frame counter, → RUN.
  - Without tlast → DRAIN, `err`, no commit.
- DRAIN accepts and discards beats until a tlast handshake, then → HDR.
- RUN: `en` = 1; each `frame_done` increments a 16-bit counter.
  - When `frame_done` arrives with count == frames-1 → HDR, `done` pulses.
  - frames == 0: run until `abort`.
  - `abort` → HDR, no `done`.
  - `abort` and a final `frame_done` in the same cycle: abort wins, no `done`.
- Committed outputs hold their values outside commit cycles, including after the run ends.
- Shadow registers are never visible on the outputs before commit.

## Timing
- Reset values: all outputs 0; state HDR. `s00_axis_tready` = 0 during reset and 1 from the first cycle after reset is released.
- `s00_axis_tready` is registered and state-decoded: 1 in HDR, CFG, BAR and DRAIN; 0 in RUN. No combinational path from tvalid to tready.
- Commit latency: final-beat handshake at edge N → outputs, `en` and `busy` valid after edge N+1.
- Run end: a qualifying `frame_done` or `abort` sampled at edge M → `en` = 0, `busy` = 0 and `done` (if applicable) after edge M+1. `s00_axis_tready` = 1 after M+1.
- `frame_done` outside RUN is ignored.
- `rst` mid-packet or mid-run: FSM returns to HDR, all outputs return to reset values, and the partial packet is lost. The upstream source must restart the packet.

## Configuration
- `LBM_CFG_MAGIC_CHECK_EN`:
  - Defined: beat 0 [15:0] must equal 16'h4C42, otherwise the DRAIN/`err` path is taken.
  - Undefined: [15:0] is ignored, `err` is raised only by length errors, and the magic comparator is not synthesized.

## Test plan
- Good 44-beat packet: omega = 16'h0E00, step = 100, frames = 3, barrier bit 1250 = 1 → one cycle after the last handshake `en` = 1, `busy` = 1, `barriers[1250]` = 1, all other barrier bits 0. After 3 `frame_done` pulses: `en` = 0, `done` for 1 cycle.
- Random tvalid gaps over the same packet → identical committed values; tready never drops outside RUN.
- tlast on beat 10 → `err` = 1, outputs unchanged (all 0 after reset), state HDR, next packet accepted.
- Bad magic 16'h1234, 44 beats → `err` = 1, all beats drained, no commit. With the macro undefined: commit occurs, `err` = 0.
- frames = 0: 100 `frame_done` pulses keep `en` = 1; `abort` → `en` = 0 next cycle, no `done`. Same-cycle `abort` with the last `frame_done` when frames = 2 → no `done`.
- `rst` asserted during beat 20 → all outputs 0, tready 0 during reset. A new complete packet afterwards commits correctly.

Source files
------------

// File: rtl/lbm_config_loader.sv
// lbm_config_loader: AXI-Stream config packet loader and run controller for the LBM solver; magic check enabled by LBM_CFG_MAGIC_CHECK_EN
module lbm_config_loader #(
    parameter int DEPTH      = 2500,
    parameter int DATA_WIDTH = 16,
    parameter int BAR_BEATS  = (DEPTH + 63) / 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         s00_axis_tvalid,
    input  logic [63:0]                  s00_axis_tdata,
    input  logic [7:0]                   s00_axis_tstrb,
    input  logic                         s00_axis_tlast,
    output logic                         s00_axis_tready,
    input  logic                         frame_done,
    input  logic                         abort,
    output logic [DEPTH-1:0]             barriers,
    output logic signed [15:0]           omega,
    output logic [31:0]                  step,
    output logic [DATA_WIDTH-1:0]        init_c0,
    output logic [DATA_WIDTH-1:0]        init_cn,
    output logic [DATA_WIDTH-1:0]        init_cne,
    output logic [DATA_WIDTH-1:0]        init_ce,
    output logic [DATA_WIDTH-1:0]        init_cse,
    output logic [DATA_WIDTH-1:0]        init_cs,
    output logic [DATA_WIDTH-1:0]        init_csw,
    output logic [DATA_WIDTH-1:0]        init_cw,
    output logic [DATA_WIDTH-1:0]        init_cnw,
    output logic                         en,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);
    localparam int SH_W = BAR_BEATS * 64;
    localparam logic [5:0] LAST = 6'(BAR_BEATS + 3);

    typedef enum logic [2:0] {HDR, CFG, BAR, DRAIN, RUN} state_t;
    state_t state;
    logic [5:0] cnt;
    logic [15:0] fcnt, frames_q, sh_frames, sh_omega;
    logic [31:0] sh_step;
    logic [8:0][15:0] sh_c;
    logic [SH_W-1:0] sh_bar, bar_next;
    logic hs, bad_magic, unused_ok;

    assign hs = s00_axis_tvalid & s00_axis_tready;
    assign bar_next = {s00_axis_tdata, sh_bar[SH_W-1:64]};
    assign unused_ok = ^{s00_axis_tstrb, bar_next[SH_W-1:DEPTH]};
`ifdef LBM_CFG_MAGIC_CHECK_EN
    assign bad_magic = s00_axis_tdata[15:0] != 16'h4C42;
`else
    assign bad_magic = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HDR;
            cnt <= '0;
            fcnt <= '0;
            frames_q <= '0;
            s00_axis_tready <= 1'b0;
            en <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            err <= 1'b0;
            barriers <= '0;
            omega <= '0;
            step <= '0;
            init_c0 <= '0;
            init_cn <= '0;
            init_cne <= '0;
            init_ce <= '0;
            init_cse <= '0;
            init_cs <= '0;
            init_csw <= '0;
            init_cw <= '0;
            init_cnw <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                HDR: begin
                    s00_axis_tready <= 1'b1;
                    if (hs) begin
                        cnt <= 6'd1;
                        sh_omega <= s00_axis_tdata[31:16];
                        sh_step <= s00_axis_tdata[63:32];
                        if (bad_magic || s00_axis_tlast) begin
                            err <= 1'b1;
                            state <= s00_axis_tlast ? HDR : DRAIN;
                        end else
                            state <= CFG;
                    end
                end
                CFG: if (hs) begin
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd1)
                        sh_c[3:0] <= s00_axis_tdata;
                    else if (cnt == 6'd2)
                        sh_c[7:4] <= s00_axis_tdata;
                    else begin
                        sh_c[8] <= s00_axis_tdata[15:0];
                        sh_frames <= s00_axis_tdata[31:16];
                    end
                    if (s00_axis_tlast) begin
                        err <= 1'b1;
                        state <= HDR;
                    end else if (cnt == 6'd3)
                        state <= BAR;
                end
                BAR: if (hs) begin
                    cnt <= cnt + 6'd1;
                    sh_bar <= bar_next;
                    if (cnt == LAST && s00_axis_tlast) begin
                        barriers <= bar_next[DEPTH-1:0];
                        omega <= sh_omega;
                        step <= sh_step;
                        frames_q <= sh_frames;
                        init_c0 <= DATA_WIDTH'(sh_c[0]);
                        init_cn <= DATA_WIDTH'(sh_c[1]);
                        init_cne <= DATA_WIDTH'(sh_c[2]);
                        init_ce <= DATA_WIDTH'(sh_c[3]);
                        init_cse <= DATA_WIDTH'(sh_c[4]);
                        init_cs <= DATA_WIDTH'(sh_c[5]);
                        init_csw <= DATA_WIDTH'(sh_c[6]);
                        init_cw <= DATA_WIDTH'(sh_c[7]);
                        init_cnw <= DATA_WIDTH'(sh_c[8]);
                        err <= 1'b0;
                        fcnt <= '0;
                        en <= 1'b1;
                        busy <= 1'b1;
                        s00_axis_tready <= 1'b0;
                        state <= RUN;
                    end else if (cnt == LAST || s00_axis_tlast) begin
                        err <= 1'b1;
                        state <= s00_axis_tlast ? HDR : DRAIN;
                    end
                end
                DRAIN: if (hs && s00_axis_tlast) state <= HDR;
                RUN: begin
                    if (abort || (frame_done && frames_q != 16'd0 && fcnt == frames_q - 16'd1)) begin
                        done <= ~abort;
                        en <= 1'b0;
                        busy <= 1'b0;
                        s00_axis_tready <= 1'b1;
                        state <= HDR;
                    end else if (frame_done)
                        fcnt <= fcnt + 16'd1;
                end
                default: state <= HDR;
            endcase
        end
    end
endmodule

// File: tb/tb_lbm_config_loader.sv
// tb_lbm_config_loader: table-driven, hand-written and randomized checks of lbm_config_loader against a packet-level model
module tb_lbm_config_loader;
    localparam int DEPTH = 2500;
    localparam int LASTB = 43;
`ifdef LBM_CFG_MAGIC_CHECK_EN
    localparam bit MAGIC_EN = 1'b1;
`else
    localparam bit MAGIC_EN = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b1;
    logic tvalid = 1'b0, tlast = 1'b0, tready;
    logic [63:0] tdata = '0;
    logic [7:0] tstrb = '0;
    logic frame_done = 1'b0, abort = 1'b0;
    logic [DEPTH-1:0] barriers;
    logic signed [15:0] omega;
    logic [31:0] step;
    logic [15:0] c0, cn, cne, ce, cse, cs, csw, cw, cnw;
    logic en, busy, done, err;

    lbm_config_loader dut (
        .clk(clk), .rst(rst),
        .s00_axis_tvalid(tvalid), .s00_axis_tdata(tdata), .s00_axis_tstrb(tstrb),
        .s00_axis_tlast(tlast), .s00_axis_tready(tready),
        .frame_done(frame_done), .abort(abort),
        .barriers(barriers), .omega(omega), .step(step),
        .init_c0(c0), .init_cn(cn), .init_cne(cne), .init_ce(ce), .init_cse(cse),
        .init_cs(cs), .init_csw(csw), .init_cw(cw), .init_cnw(cnw),
        .en(en), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, done_cnt = 0, vec_id = 0;
    always @(negedge clk) if (done) done_cnt++;

    logic [63:0] pk [64];
    logic pl [64];
    int pn;

    logic [15:0] m_omega, m_frames;
    logic [31:0] m_step;
    logic [15:0] m_c [9];
    logic [DEPTH-1:0] m_bar;
    logic m_err, m_commit;

    typedef struct {
        logic [15:0] magic;
        logic [15:0] om;
        logic [31:0] st;
        logic [15:0] fr;
        int bar_idx;
        int last_at;
        int gap;
        bit exp_commit;
        bit exp_err;
    } vec_t;
    vec_t tv [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL [%0d] %s: got %0h expected %0h", vec_id, name, act, exp);
        end
    endtask

    task automatic chk_bar();
        int diff = 0;
        checks++;
        for (int i = 0; i < DEPTH; i++) if (barriers[i] !== m_bar[i]) diff++;
        if (diff != 0) begin
            errors++;
            $display("FAIL [%0d] barriers: %0d bits differ from expected", vec_id, diff);
        end
    endtask

    task automatic model_reset();
        m_omega = '0; m_step = '0; m_frames = '0; m_bar = '0; m_err = 1'b0; m_commit = 1'b0;
        for (int i = 0; i < 9; i++) m_c[i] = '0;
    endtask

    // Packet-level view: everything up to the first tlast is consumed; only a
    // well-formed packet whose first tlast lands on the final barrier beat commits.
    task automatic model_apply();
        int l = pn - 1;
        bit bad = MAGIC_EN && pk[0][15:0] != 16'h4C42;
        for (int i = pn - 1; i >= 0; i--) if (pl[i]) l = i;
        m_commit = !bad && l == LASTB;
        if (m_commit) begin
            m_omega = pk[0][31:16];
            m_step = pk[0][63:32];
            for (int w = 0; w < 4; w++) begin
                m_c[w] = pk[1][16*w +: 16];
                m_c[4+w] = pk[2][16*w +: 16];
            end
            m_c[8] = pk[3][15:0];
            m_frames = pk[3][31:16];
            for (int i = 0; i < DEPTH; i++) m_bar[i] = pk[4 + i / 64][i % 64];
            m_err = 1'b0;
        end else
            m_err = 1'b1;
    endtask

    task automatic build(input logic [15:0] magic, input logic [15:0] om, input logic [31:0] st,
                         input logic [15:0] fr, input int bar_idx, input int last_at, input bit rnd);
        pk[0] = {st, om, magic};
        pk[1] = {$urandom, $urandom};
        pk[2] = {$urandom, $urandom};
        pk[3] = {$urandom, fr, 16'($urandom)};
        for (int b = 4; b < 64; b++) pk[b] = rnd ? {$urandom, $urandom} : 64'd0;
        if (bar_idx >= 0) pk[4 + bar_idx / 64][bar_idx % 64] = 1'b1;
        pk[LASTB][63:4] = '1;
        for (int i = 0; i < 64; i++) pl[i] = (i == last_at);
        pn = last_at + 1;
    endtask

    task automatic send(input int gap);
        int low = 0;
        for (int i = 0; i < pn; i++) begin
            int guard = 0;
            bit sent = 1'b0;
            while (!sent && guard < 500) begin
                @(negedge clk);
                guard++;
                tvalid = $urandom_range(99) >= gap;
                tdata = pk[i];
                tlast = pl[i];
                tstrb = 8'($urandom);
                if (!tready) low++;
                sent = tvalid && tready;
                @(posedge clk);
            end
            if (!sent) begin
                chk("beat_timeout", 64'(i), 64'hFFFF);
                break;
            end
        end
        @(negedge clk);
        tvalid = 1'b0;
        tlast = 1'b0;
        chk("tready_low_cycles", 64'(low), 0);
    endtask

    task automatic check_outputs(input bit exp_run);
        @(posedge clk);
        @(negedge clk);
        chk("en", en, exp_run);
        chk("busy", busy, exp_run);
        chk("tready", tready, !exp_run);
        chk("err", err, m_err);
        chk("omega", $unsigned(omega), m_omega);
        chk("step", step, m_step);
        chk("c0", c0, m_c[0]); chk("cn", cn, m_c[1]); chk("cne", cne, m_c[2]);
        chk("ce", ce, m_c[3]); chk("cse", cse, m_c[4]); chk("cs", cs, m_c[5]);
        chk("csw", csw, m_c[6]); chk("cw", cw, m_c[7]); chk("cnw", cnw, m_c[8]);
        chk_bar();
    endtask

    task automatic pulse(input bit fd, input bit ab);
        @(negedge clk);
        frame_done = fd;
        abort = ab;
        @(negedge clk);
        frame_done = 1'b0;
        abort = 1'b0;
    endtask

    task automatic finish_check(input int d0, input int exp_done);
        @(posedge clk);
        @(negedge clk);
        chk("en_after_end", en, 0);
        chk("busy_after_end", busy, 0);
        chk("tready_after_end", tready, 1);
        repeat (2) @(negedge clk);
        chk("done_pulses", 64'(done_cnt - d0), 64'(exp_done));
        chk("omega_held", $unsigned(omega), m_omega);
    endtask

    task automatic run_frames(input int f);
        int d0 = done_cnt;
        chk("tready_in_run", tready, 0);
        for (int k = 0; k < f - 1; k++) begin
            pulse(1'b1, 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        chk("en_before_last", en, 1);
        chk("done_early", 64'(done_cnt - d0), 0);
        pulse(1'b1, 1'b0);
        finish_check(d0, 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int d0;
        model_reset();
        tv[0] = '{16'h4C42, 16'h0E00, 32'd100, 16'd3, 1250, 10, 0, 1'b0, 1'b1};
        tv[1] = '{16'h4C42, 16'h0E00, 32'd100, 16'd3, 1250, 0, 0, 1'b0, 1'b1};
        tv[2] = '{16'h4C42, 16'h0E00, 32'd100, 16'd3, 1250, 3, 30, 1'b0, 1'b1};
        tv[3] = '{16'h4C42, 16'h0E00, 32'd100, 16'd3, 1250, 43, 0, 1'b1, 1'b0};
        tv[4] = '{16'h4C42, 16'h0E00, 32'd100, 16'd3, 1250, 43, 40, 1'b1, 1'b0};
        tv[5] = '{16'h1234, 16'hF123, 32'd7, 16'd1, 5, 43, 10, !MAGIC_EN, MAGIC_EN};
        tv[6] = '{16'h4C42, 16'h0100, 32'd9, 16'd2, 0, 45, 20, 1'b0, 1'b1};
        tv[7] = '{16'h4C42, 16'h8001, 32'hDEADBEEF, 16'd1, 2499, 43, 20, 1'b1, 1'b0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_tready", tready, 0);
        chk("rst_en", en, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
        chk("rst_err", err, 0); chk("rst_omega", $unsigned(omega), 0);
        chk("rst_step", step, 0); chk("rst_c0", c0, 0);
        chk_bar();
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("tready_after_rst", tready, 1);

        for (int v = 0; v < 8; v++) begin
            vec_id = v;
            pulse(1'b1, 1'b0);
            build(tv[v].magic, tv[v].om, tv[v].st, tv[v].fr, tv[v].bar_idx, tv[v].last_at, 1'b0);
            send(tv[v].gap);
            model_apply();
            check_outputs(tv[v].exp_commit);
            chk("tbl_err", err, tv[v].exp_err);
            if (en) run_frames(int'(m_frames));
        end

        vec_id = 100;
        build(16'h4C42, 16'h0A00, 32'd5, 16'd0, 77, LASTB, 1'b0);
        send(0);
        model_apply();
        check_outputs(1'b1);
        d0 = done_cnt;
        for (int k = 0; k < 100; k++) pulse(1'b1, 1'b0);
        chk("en_frames0", en, 1);
        chk("done_frames0", 64'(done_cnt - d0), 0);
        pulse(1'b0, 1'b1);
        finish_check(d0, 0);

        vec_id = 101;
        build(16'h4C42, 16'h0B00, 32'd6, 16'd2, 78, LASTB, 1'b0);
        send(10);
        model_apply();
        check_outputs(1'b1);
        d0 = done_cnt;
        pulse(1'b1, 1'b0);
        chk("en_abort_race", en, 1);
        pulse(1'b1, 1'b1);
        finish_check(d0, 0);

        vec_id = 102;
        build(16'h4C42, 16'h0C00, 32'd11, 16'd1, 300, LASTB, 1'b1);
        pn = 21;
        pl[LASTB] = 1'b0;
        send(0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        model_reset();
        chk("midrst_tready", tready, 0);
        chk("midrst_err", err, 0);
        chk("midrst_step", step, 0);
        chk("midrst_omega", $unsigned(omega), 0);
        chk_bar();
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("tready_after_midrst", tready, 1);
        build(16'h4C42, 16'h0D00, 32'd12, 16'd2, 1999, LASTB, 1'b1);
        send(25);
        model_apply();
        check_outputs(1'b1);
        run_frames(2);

        for (int r = 0; r < 10; r++) begin
            int sel = $urandom_range(0, 9);
            int la = sel == 7 ? $urandom_range(0, 42) : sel == 8 ? $urandom_range(44, 47) : LASTB;
            logic [15:0] mg = sel == 9 ? 16'($urandom) : 16'h4C42;
            vec_id = 200 + r;
            build(mg, 16'($urandom), $urandom, 16'($urandom_range(1, 3)), -1, la, 1'b1);
            send($urandom_range(0, 50));
            model_apply();
            check_outputs(m_commit);
            if (m_commit) begin
                if ($urandom_range(0, 3) == 0) begin
                    d0 = done_cnt;
                    pulse(1'b0, 1'b1);
                    finish_check(d0, 0);
                end else
                    run_frames(int'(m_frames));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
